// File: rtl/bus_grant_encoder.sv
// bus_grant_encoder: registered request-to-index encoder, fixed priority (MODE=0) or round-robin (MODE=1).
module bus_grant_encoder #(
    parameter int N    = 32,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clock_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic         hold_i,
    input  logic [N-1:0] req_i,
    output logic [W-1:0] grant_idx_o,
    output logic         grant_valid_o,
    output logic         multi_req_o,
    output logic [N-1:0] grant_onehot_o
);
    logic [W-1:0]   idx_q, idx_d, last_q, last_d, g;
    logic           valid_q, valid_d, multi_q, multi_d, fire, found;
    logic [N-1:0]   onehot_q, onehot_d, rot;
    logic [2*N-1:0] dbl;
    int             start, pos;

    assign fire = enable_i && |req_i;

    // Rotate req so the search origin sits at bit 0, then take the lowest set bit.
    always_comb begin
        start = (MODE == 1 && int'(last_q) < N - 1) ? int'(last_q) + 1 : 0;
        dbl = {req_i, req_i} >> start;
        rot = dbl[N-1:0];
        g = '0;
        pos = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos = start + k;
                g = W'(pos >= N ? pos - N : pos);
            end
        end
        idx_d    = fire ? g : idx_q;
        valid_d  = fire;
        multi_d  = fire && |(req_i & (req_i - N'(1)));
        onehot_d = fire ? N'(1) << g : '0;
        last_d   = (MODE == 1 && fire) ? g : last_q;
    end

    always_ff @(posedge clock_i or negedge clear_i) begin
        if (!clear_i) begin
            idx_q    <= '0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
            onehot_q <= '0;
            last_q   <= W'(N - 1);
        end else if (!hold_i) begin
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            onehot_q <= onehot_d;
            last_q   <= last_d;
        end
    end

    assign grant_idx_o    = idx_q;
    assign grant_valid_o  = valid_q;
    assign multi_req_o    = multi_q;
    assign grant_onehot_o = onehot_q;
endmodule

// File: tb/tb_bus_grant_encoder.sv
// tb_bus_grant_encoder: random and directed checks of three encoder configurations against a reference model.
module tb_bus_grant_encoder;
    logic        clk = 1'b0, clear = 1'b0, enable = 1'b0, hold = 1'b0;
    logic [31:0] req = '0;
    logic [4:0]  req5 = '0;
    logic [4:0]  idx0, idx1;
    logic [2:0]  idx5;
    logic        v0, v1, v5, m0, m1, m5;
    logic [31:0] oh0, oh1;
    logic [4:0]  oh5;
    int          n_chk = 0, n_pass = 0;

    int          nn[3] = '{32, 32, 5};
    int          md[3] = '{0, 1, 1};
    int          mi[3], ml[3];
    logic        mv[3], mm[3];
    logic [63:0] moh[3];
    logic [63:0] o_idx[3], o_v[3], o_m[3], o_oh[3];

    always #5 clk = ~clk;

    bus_grant_encoder #(.N(32), .MODE(0)) u0 (.clock_i(clk), .clear_i(clear), .enable_i(enable), .hold_i(hold),
        .req_i(req), .grant_idx_o(idx0), .grant_valid_o(v0), .multi_req_o(m0), .grant_onehot_o(oh0));
    bus_grant_encoder #(.N(32), .MODE(1)) u1 (.clock_i(clk), .clear_i(clear), .enable_i(enable), .hold_i(hold),
        .req_i(req), .grant_idx_o(idx1), .grant_valid_o(v1), .multi_req_o(m1), .grant_onehot_o(oh1));
    bus_grant_encoder #(.N(5), .MODE(1)) u2 (.clock_i(clk), .clear_i(clear), .enable_i(enable), .hold_i(hold),
        .req_i(req5), .grant_idx_o(idx5), .grant_valid_o(v5), .multi_req_o(m5), .grant_onehot_o(oh5));

    assign o_idx = '{64'(idx0), 64'(idx1), 64'(idx5)};
    assign o_v   = '{64'(v0), 64'(v1), 64'(v5)};
    assign o_m   = '{64'(m0), 64'(m1), 64'(m5)};
    assign o_oh  = '{64'(oh0), 64'(oh1), 64'(oh5)};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            mi[u] = 0; mv[u] = 1'b0; mm[u] = 1'b0; moh[u] = '0; ml[u] = nn[u] - 1;
        end
    endtask

    // Grant = first requester found walking upward from the origin, wrapping modulo N.
    task automatic model_step();
        logic [63:0] r;
        int          org, g;
        for (int u = 0; u < 3; u++) begin
            r = (u == 2) ? 64'(req5) : 64'(req);
            if (hold) continue;
            if (!enable || r == 0) begin
                mv[u] = 1'b0; mm[u] = 1'b0; moh[u] = '0;
            end else begin
                org = md[u] ? (ml[u] + 1) % nn[u] : 0;
                g = -1;
                for (int k = 0; k < nn[u]; k++)
                    if (g < 0 && r[(org + k) % nn[u]]) g = (org + k) % nn[u];
                mi[u] = g; mv[u] = 1'b1; mm[u] = $countones(r) > 1; moh[u] = 64'd1 << g;
                if (md[u]) ml[u] = g;
            end
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d idx", u), o_idx[u], 64'(mi[u]));
            chk($sformatf("u%0d valid", u), o_v[u], 64'(mv[u]));
            chk($sformatf("u%0d multi", u), o_m[u], 64'(mm[u]));
            chk($sformatf("u%0d onehot", u), o_oh[u], moh[u]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Called just after a rising edge: asserts clear mid-cycle and checks before the next edge.
    task automatic do_reset();
        #3 clear = 1'b0;
        #1 model_reset();
        check_all();
        #2 clear = 1'b1;
    endtask

    initial begin
        model_reset();
        #12 clear = 1'b1;
        enable = 1'b1;
        tick();
        chk("t1 idle valid", 64'(v1), 64'd0);
        req = 32'hFFFF_0000; req5 = 5'b11000;
        tick();
        tick();
        do_reset();
        chk("t1 async valid", 64'(v1), 64'd0);
        req = '0;
        tick();
        chk("t1 zero req valid", 64'(v0), 64'd0);
        for (int i = 0; i < 32; i++) begin
            req = 32'd1 << i; req5 = 5'd1 << (i % 5);
            tick();
            chk("t2 fp idx", 64'(idx0), 64'(i));
            chk("t2 rr idx", 64'(idx1), 64'(i));
            chk("t2 rr multi", 64'(m1), 64'd0);
        end
        @(posedge clk); #1;
        do_reset();
        req = 32'h8000_0410; req5 = 5'b10001;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3 fp idx", 64'(idx0), 64'd4);
            chk("t4 rr idx", 64'(idx1), 64'(c == 0 ? 4 : c == 1 ? 10 : c == 2 ? 31 : c == 3 ? 4 : 10));
            chk("t4 rr multi", 64'(m1), 64'd1);
            chk("t6 n5 idx", 64'(idx5), 64'(c % 2 == 0 ? 0 : 4));
        end
        hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            req = $urandom; req5 = 5'($urandom);
            tick();
            chk("t5 hold idx", 64'(idx1), 64'd10);
            chk("t5 hold valid", 64'(v1), 64'd1);
        end
        hold = 1'b0; enable = 1'b0;
        tick();
        chk("t5 dis valid", 64'(v1), 64'd0);
        chk("t5 dis idx", 64'(idx1), 64'd10);
        enable = 1'b1; req = 32'hFFFF_FFFF;
        tick();
        chk("t5 resume idx", 64'(idx1), 64'd11);
        for (int c = 0; c < 600; c++) begin
            hold = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = 32'd1 << $urandom_range(0, 31);
                2: req = $urandom;
                default: req = $urandom & $urandom & $urandom;
            endcase
            req5 = 5'($urandom);
            if ($urandom_range(0, 49) == 0) do_reset();
            tick();
            chk("n5 range", 64'(idx5 <= 3'd4), 64'd1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
